// File: rtl/music_pkg.sv
// Shared definitions for the music playback blocks (tone_generator, music_streamer).
package music_pkg;
    localparam int TONE_W_DEF = 24;
    localparam int VOL_W_DEF  = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    typedef struct packed {
        logic sq;
        logic active;
        logic tick;
    } tone_out_t;
endpackage

// File: rtl/tone_generator_if.sv
// Control and speaker-drive bundle between the streamer side and tone_generator.
interface tone_generator_if #(
    parameter int TONE_W = music_pkg::TONE_W_DEF,
    parameter int VOL_W  = music_pkg::VOL_W_DEF
);
    logic [TONE_W-1:0] tone;
    logic              output_enable;
    logic [VOL_W-1:0]  volume;
    logic              square_wave_out;
    logic              note_active;
    logic              period_tick;

    modport master (
        output tone, output_enable, volume,
        input  square_wave_out, note_active, period_tick
    );
    modport slave (
        input  tone, output_enable, volume,
        output square_wave_out, note_active, period_tick
    );
endinterface

// File: rtl/volume_pwm.sv
// Free-running carrier counter; duty_o is high while the carrier is at or below volume.
module volume_pwm import music_pkg::*; #(
    parameter int VOL_W = VOL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VOL_W-1:0] volume_i,
    output logic             duty_o
);
    logic [VOL_W-1:0] carrier_q, carrier_d;

    // Wraps naturally at 2**VOL_W; never touched by tone changes.
    assign carrier_d = carrier_q + VOL_W'(1);
    assign duty_o    = (carrier_q <= volume_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q <= '0;
        end else begin
            carrier_q <= carrier_d;
        end
    end
endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator: half-period counter, IDLE/PLAY control and registered outputs.
//   state | meaning
//   IDLE  | active_tone == 0, outputs quiet, waiting for enable and a nonzero tone
//   PLAY  | active_tone != 0, counting half-periods and toggling phase
module tone_generator import music_pkg::*; #(
    parameter int TONE_W = TONE_W_DEF,
    parameter int VOL_W  = VOL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    tone_generator_if.slave  bus
);
    logic [TONE_W-1:0] active_q, active_d;
    logic [TONE_W-1:0] hp_q, hp_d;
    logic              phase_q, phase_d;
    logic [0:0]        state;
    logic              boundary;
    logic              duty;
    tone_out_t         out_q, out_d;

    volume_pwm #(.VOL_W(VOL_W)) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .volume_i (bus.volume),
        .duty_o   (duty)
    );

    assign state    = (active_q != '0) ? ST_PLAY : ST_IDLE;
    assign boundary = (hp_q == active_q - TONE_W'(1));

    always_comb begin
        active_d = active_q;
        hp_d     = hp_q;
        phase_d  = phase_q;
        // Disable wins over everything, including a coincident boundary.
        if (!bus.output_enable) begin
            active_d = '0;
            hp_d     = '0;
            phase_d  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.tone != '0) begin
                        active_d = bus.tone;
                        hp_d     = '0;
                        phase_d  = 1'b1;
                    end
                end
                ST_PLAY: begin
                    // The tone input is only looked at here, so a half-period never glitches.
                    if (boundary) begin
                        hp_d = '0;
                        if (bus.tone == '0) begin
                            active_d = '0;
                            phase_d  = 1'b0;
                        end else begin
                            active_d = bus.tone;
                            phase_d  = ~phase_q;
                        end
                    end else begin
                        hp_d = hp_q + TONE_W'(1);
                    end
                end
                default: begin
                    active_d = '0;
                    hp_d     = '0;
                    phase_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_d        = '0;
        out_d.sq     = phase_q & duty & (state == ST_PLAY);
        out_d.active = (state == ST_PLAY);
        // A 1->0 phase change caused by dropping to IDLE is not a period tick.
        out_d.tick   = phase_q & ~phase_d & (active_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            hp_q     <= '0;
            phase_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            active_q <= active_d;
            hp_q     <= hp_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
        end
    end

    assign bus.square_wave_out = out_q.sq;
    assign bus.note_active     = out_q.active;
    assign bus.period_tick     = out_q.tick;
endmodule

// File: tb/tb_tone_generator.sv
// Randomized and directed bench for tone_generator with a queue-based scoreboard.
module tb_tone_generator;
    logic clk;
    logic rst;

    tone_generator_if #(.TONE_W(24), .VOL_W(3)) bus ();

    tone_generator #(.TONE_W(24), .VOL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int shown = 0;

    // Reference model: note length, cycles left in the current half-period, level, carrier.
    int m_tone = 0;
    int m_left = 0;
    int m_ph   = 0;
    int m_car  = 0;
    logic [2:0] exp_q [$];

    always @(posedge clk) begin
        int nt;
        int old_ph;
        logic e_sq, e_na, e_tk;
        if (rst) begin
            m_tone = 0; m_left = 0; m_ph = 0; m_car = 0;
            exp_q.push_back(3'b000);
        end else begin
            e_na   = (m_tone != 0);
            e_sq   = (m_ph == 1) && e_na && (m_car <= int'(bus.volume));
            e_tk   = 1'b0;
            old_ph = m_ph;
            nt     = int'(bus.tone);
            if (!bus.output_enable) begin
                m_tone = 0; m_left = 0; m_ph = 0;
            end else if (m_tone == 0) begin
                if (nt != 0) begin
                    m_tone = nt; m_left = nt; m_ph = 1;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (nt == 0) begin
                        m_tone = 0; m_ph = 0;
                    end else begin
                        m_tone = nt; m_left = nt; m_ph = 1 - m_ph;
                        e_tk = (old_ph == 1);
                    end
                end
            end
            m_car = (m_car + 1) % 8;
            exp_q.push_back({e_sq, e_na, e_tk});
        end
    end

    task automatic check(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            if (shown < 30) begin
                shown++;
                $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("square_wave_out", bus.square_wave_out, e[2]);
            check("note_active",     bus.note_active,     e[1]);
            check("period_tick",     bus.period_tick,     e[0]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.output_enable = 1'b0;
        bus.tone = '0;
        bus.volume = 3'd7;
        step(3);

        rst = 1'b0;
        bus.output_enable = 1'b1;
        bus.tone = 24'd4;
        step(30);
        bus.tone = 24'd2;
        step(20);

        bus.tone = 24'd3;
        bus.volume = 3'd1;
        step(30);

        bus.output_enable = 1'b0;
        step(1);
        bus.output_enable = 1'b1;
        step(15);

        bus.tone = 24'd1;
        bus.volume = 3'd7;
        step(10);
        bus.tone = 24'd0;
        step(5);
        bus.tone = 24'd1;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);

        for (int seg = 0; seg < 250; seg++) begin
            rst = ($urandom_range(0, 40) == 0);
            bus.output_enable = ($urandom_range(0, 7) != 0);
            bus.volume = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) bus.tone = 24'd0;
            else bus.tone = 24'($urandom_range(1, 6));
            step(int'($urandom_range(1, 20)));
        end

        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
